// File: rtl/aqed_fc_tracker.sv
// ---------------------------------------------------------------------------
// aqed_fc_tracker
//
// A-QED functional-consistency tracker for a memory core running in FIFO
// mode. It snoops accepted input words and consumed output words. A free
// "original" mark tags one accepted word. A later accepted word with the same
// data and a "duplicate" mark is tagged as its twin. The core outputs with
// the same ordinals are captured and compared. qed_done/qed_check feed the
// formal property qed_done |-> qed_check.
//
// Ports
//   clk           clock, rising edge
//   reset         synchronous, active-high reset
//   clk_en        global enable; when 0 all state holds
//   in_data       word presented to the core's data input
//   in_valid      core write enable; a word is accepted on clk_en && in_valid
//   orig_mark     tags the current accepted word as the original
//   dup_mark      tags the current accepted word as the duplicate
//   out_data      core data output
//   out_valid     core output valid
//   out_rdy       consumer ready; an output is consumed on
//                 clk_en && out_valid && out_rdy
//   orig_captured original input has been recorded
//   qed_done      both outputs captured, comparison valid (sticky)
//   qed_check     comparison result; 1 whenever qed_done is 0
//
// FSM states
//   state        | meaning
//   -------------+----------------------------------------------------------
//   ST_IDLE      | waiting for an accepted word tagged as original
//   ST_ORIG_SET  | original recorded; waiting for a matching duplicate
//   ST_DUP_SET   | duplicate recorded; waiting for both outputs
//   ST_DONE      | comparison latched; all traffic ignored until reset
// ---------------------------------------------------------------------------
module aqed_fc_tracker #(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clk_en,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  input  logic                  orig_mark,
  input  logic                  dup_mark,
  input  logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_valid,
  input  logic                  out_rdy,
  output logic                  orig_captured,
  output logic                  qed_done,
  output logic                  qed_check
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ORIG_SET = 2'd1,
    ST_DUP_SET  = 2'd2,
    ST_DONE     = 2'd3
  } state_t;

  state_t                state_q;

  logic [CNT_WIDTH-1:0]  in_cnt_q,  in_cnt_d;
  logic [CNT_WIDTH-1:0]  out_cnt_q, out_cnt_d;

  logic [DATA_WIDTH-1:0] orig_data_q;
  logic [CNT_WIDTH-1:0]  orig_idx_q;
  logic [CNT_WIDTH-1:0]  dup_idx_q;
  logic [DATA_WIDTH-1:0] orig_out_q;
  logic [DATA_WIDTH-1:0] dup_out_q;
  logic                  orig_out_vld_q;
  logic                  dup_out_vld_q;

  logic                  orig_captured_q;
  logic                  qed_done_q;
  logic                  qed_check_q;

  logic                  acc;
  logic                  cons;
  logic                  in_sat;
  logic                  out_sat;
  logic                  markable;
  logic                  orig_out_hit;
  logic                  dup_out_hit;

  assign acc      = clk_en && in_valid;
  assign cons     = clk_en && out_valid && out_rdy;
  assign in_sat   = (in_cnt_q == {CNT_WIDTH{1'b1}});
  assign out_sat  = (out_cnt_q == {CNT_WIDTH{1'b1}});
  // A word accepted at the saturated ordinal has no unique index, so it is
  // never eligible for marking.
  assign markable = acc && !in_sat;

  // Capture hits use the pre-increment output ordinal.
  assign orig_out_hit = ((state_q == ST_ORIG_SET) || (state_q == ST_DUP_SET)) &&
                        cons && (out_cnt_q == orig_idx_q) && !orig_out_vld_q;
  assign dup_out_hit  = (state_q == ST_DUP_SET) && cons &&
                        (out_cnt_q == dup_idx_q);

  // Ordinal counters run regardless of the FSM and saturate at all-ones.
  always_comb begin
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    if (acc && !in_sat) begin
      in_cnt_d = in_cnt_q + CNT_WIDTH'(1);
    end
    if (cons && !out_sat) begin
      out_cnt_d = out_cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
    end else begin
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      orig_data_q     <= '0;
      orig_idx_q      <= '0;
      dup_idx_q       <= '0;
      orig_out_q      <= '0;
      dup_out_q       <= '0;
      orig_out_vld_q  <= 1'b0;
      dup_out_vld_q   <= 1'b0;
      orig_captured_q <= 1'b0;
      qed_done_q      <= 1'b0;
      qed_check_q     <= 1'b1;
    end else if (clk_en) begin
      case (state_q)
        ST_IDLE: begin
          // dup_mark is meaningless before an original exists.
          if (markable && orig_mark) begin
            orig_data_q     <= in_data;
            orig_idx_q      <= in_cnt_q;
            orig_captured_q <= 1'b1;
            state_q         <= ST_ORIG_SET;
          end
        end
        ST_ORIG_SET: begin
          if (markable && dup_mark && (in_data == orig_data_q)) begin
            dup_idx_q <= in_cnt_q;
            state_q   <= ST_DUP_SET;
          end
        end
        ST_DUP_SET: begin
          // Uses the registered valid flags, so DONE lands one cycle after
          // the later of the two captures.
          if (orig_out_vld_q && dup_out_vld_q) begin
            qed_done_q  <= 1'b1;
            qed_check_q <= (orig_out_q == dup_out_q);
            state_q     <= ST_DONE;
          end
        end
        ST_DONE: begin
          state_q <= ST_DONE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase

      // The original output may arrive before the duplicate is marked.
      if (orig_out_hit) begin
        orig_out_q     <= out_data;
        orig_out_vld_q <= 1'b1;
      end
      if (dup_out_hit) begin
        dup_out_q     <= out_data;
        dup_out_vld_q <= 1'b1;
      end
    end
  end

  assign orig_captured = orig_captured_q;
  assign qed_done      = qed_done_q;
  assign qed_check     = qed_check_q;

endmodule

// File: tb/tb_aqed_fc_tracker.sv
module tb_aqed_fc_tracker;

  localparam int DW  = 16;
  localparam int CW  = 4;
  localparam int MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          clk_en;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          orig_mark;
  logic          dup_mark;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_rdy;
  logic          orig_captured;
  logic          qed_done;
  logic          qed_check;

  int errors = 0;
  int checks = 0;

  // Reference model: ordinals as plain ints, -1 meaning "not tagged yet".
  int            m_in, m_out;
  int            m_orig, m_dup;
  logic [DW-1:0] m_odata, m_oval, m_dval;
  bit            m_og, m_dg, m_done, m_chk;

  aqed_fc_tracker #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk           (clk),
    .reset         (reset),
    .clk_en        (clk_en),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .orig_mark     (orig_mark),
    .dup_mark      (dup_mark),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_rdy       (out_rdy),
    .orig_captured (orig_captured),
    .qed_done      (qed_done),
    .qed_check     (qed_check)
  );

  always #5 clk = ~clk;

  task automatic model_update();
    bit acc, cons, og0, dg0;
    int oi0, di0;
    acc  = clk_en && in_valid;
    cons = clk_en && out_valid && out_rdy;
    if (reset) begin
      m_in = 0; m_out = 0; m_orig = -1; m_dup = -1;
      m_og = 0; m_dg = 0; m_done = 0; m_chk = 1;
      return;
    end
    if (!clk_en) return;
    og0 = m_og; dg0 = m_dg; oi0 = m_orig; di0 = m_dup;
    if (!m_done) begin
      if (og0 && dg0) begin
        m_done = 1;
        m_chk  = (m_oval == m_dval);
      end
      if (oi0 >= 0 && cons && m_out == oi0 && !og0) begin
        m_oval = out_data; m_og = 1;
      end
      if (di0 >= 0 && cons && m_out == di0) begin
        m_dval = out_data; m_dg = 1;
      end
      if (acc && m_in < MAX) begin
        if (oi0 < 0 && orig_mark) begin
          m_orig = m_in; m_odata = in_data;
        end else if (oi0 >= 0 && di0 < 0 && dup_mark && in_data == m_odata) begin
          m_dup = m_in;
        end
      end
    end
    if (acc && m_in < MAX) m_in++;
    if (cons && m_out < MAX) m_out++;
  endtask

  // One clock: inputs are already stable, model sees the same values the DUT
  // samples, outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    reset = 0; clk_en = 1; in_data = '0; in_valid = 0; orig_mark = 0;
    dup_mark = 0; out_data = '0; out_valid = 0; out_rdy = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    step();
    reset = 0;
  endtask

  task automatic accept(input logic [DW-1:0] d, input bit om, input bit dm);
    in_data = d; in_valid = 1; orig_mark = om; dup_mark = dm;
    step();
    in_valid = 0; orig_mark = 0; dup_mark = 0;
  endtask

  task automatic consume(input logic [DW-1:0] d);
    out_data = d; out_valid = 1; out_rdy = 1;
    step();
    out_valid = 0; out_rdy = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1;
    step();
    step();
    reset = 0;
    checks++;
    if (orig_captured !== 1'b0 || qed_done !== 1'b0 || qed_check !== 1'b1)
      $display("FAIL reset_values: got cap=%b done=%b chk=%b, expected cap=0 done=0 chk=1",
               orig_captured, qed_done, qed_check);
    if (orig_captured !== 1'b0 || qed_done !== 1'b0 || qed_check !== 1'b1) errors++;
  endtask

  task automatic test_basic(input string name, input logic [DW-1:0] third,
                            input bit exp_check, input bit with_reset);
    if (with_reset) do_reset();
    accept(16'h00AA, 1, 0);
    checks++;
    if (orig_captured !== 1'b1) begin
      errors++;
      $display("FAIL %s_orig_captured: got %b, expected 1", name, orig_captured);
    end
    accept(16'h0055, 0, 0);
    accept(16'h00AA, 0, 1);
    consume(16'h00AA);
    consume(16'h0055);
    consume(third);
    checks++;
    if (qed_done !== 1'b0 || qed_check !== 1'b1) begin
      errors++;
      $display("FAIL %s_early_done: got done=%b chk=%b, expected done=0 chk=1",
               name, qed_done, qed_check);
    end
    step();
    checks++;
    if (qed_done !== 1'b1 || qed_check !== exp_check) begin
      errors++;
      $display("FAIL %s_done: got done=%b chk=%b, expected done=1 chk=%b",
               name, qed_done, qed_check, exp_check);
    end
    checks++;
    if (qed_done !== m_done || qed_check !== m_chk) begin
      errors++;
      $display("FAIL %s_model: got done=%b chk=%b, model done=%b chk=%b",
               name, qed_done, qed_check, m_done, m_chk);
    end
  endtask

  task automatic test_done_hold();
    // Scenario 2 result (check=0) must survive further traffic.
    accept(16'h00AA, 1, 0);
    accept(16'h00AA, 0, 1);
    consume(16'h00AA);
    consume(16'h00AA);
    step();
    checks++;
    if (qed_done !== 1'b1 || qed_check !== 1'b0) begin
      errors++;
      $display("FAIL done_hold: got done=%b chk=%b, expected done=1 chk=0",
               qed_done, qed_check);
    end
  endtask

  task automatic test_dup_mismatch();
    do_reset();
    accept(16'h00AA, 1, 0);
    accept(16'h0055, 0, 1);
    accept(16'h0011, 0, 0);
    accept(16'h00AA, 0, 1);
    consume(16'h00AA);
    consume(16'h0055);
    consume(16'h0011);
    checks++;
    if (qed_done !== 1'b0) begin
      errors++;
      $display("FAIL dup_mismatch_early: got done=%b, expected 0", qed_done);
    end
    consume(16'h00AA);
    step();
    checks++;
    if (qed_done !== 1'b1 || qed_check !== 1'b1) begin
      errors++;
      $display("FAIL dup_mismatch_done: got done=%b chk=%b, expected done=1 chk=1",
               qed_done, qed_check);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    accept(16'h00AA, 1, 0);
    accept(16'h00AA, 0, 1);
    out_data = 16'h1234; out_valid = 1; out_rdy = 0;
    for (int i = 0; i < 4; i++) step();
    out_valid = 0;
    consume(16'h00AA);
    consume(16'h00AA);
    step();
    checks++;
    if (qed_done !== 1'b1 || qed_check !== 1'b1) begin
      errors++;
      $display("FAIL backpressure: got done=%b chk=%b, expected done=1 chk=1",
               qed_done, qed_check);
    end
  endtask

  task automatic test_clk_en();
    do_reset();
    clk_en = 0; in_valid = 1; in_data = 16'h0077; orig_mark = 1;
    out_valid = 1; out_rdy = 1; out_data = 16'h0077;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (orig_captured !== 1'b0) begin
        errors++;
        $display("FAIL clk_en_hold_cap: cycle %0d got %b, expected 0", i, orig_captured);
      end
    end
    idle_inputs();
    // Counters must still be at zero for this sequence to complete.
    test_basic("clk_en_after", 16'h00AA, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid();
    do_reset();
    accept(16'h00AA, 1, 0);
    accept(16'h0055, 0, 0);
    accept(16'h00AA, 0, 1);
    consume(16'h00AA);
    reset = 1;
    step();
    reset = 0;
    checks++;
    if (orig_captured !== 1'b0 || qed_done !== 1'b0 || qed_check !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid: got cap=%b done=%b chk=%b, expected cap=0 done=0 chk=1",
               orig_captured, qed_done, qed_check);
    end
    test_basic("reset_mid_after", 16'h00AA, 1'b1, 1'b0);
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < MAX; i++) accept(16'h0001, 0, 0);
    accept(16'h00AA, 1, 0);
    checks++;
    if (orig_captured !== 1'b0) begin
      errors++;
      $display("FAIL sat_orig_unmarkable: got %b, expected 0", orig_captured);
    end
    do_reset();
    for (int i = 0; i < MAX - 1; i++) accept(16'h0001, 0, 0);
    accept(16'h00AA, 1, 0);
    checks++;
    if (orig_captured !== 1'b1) begin
      errors++;
      $display("FAIL sat_orig_last: got %b, expected 1", orig_captured);
    end
    accept(16'h00AA, 0, 1);
    accept(16'h00AA, 0, 1);
    for (int i = 0; i < MAX + 1; i++) consume(16'h00AA);
    step();
    step();
    checks++;
    if (qed_done !== 1'b0 || qed_check !== 1'b1) begin
      errors++;
      $display("FAIL sat_dup_unmarkable: got done=%b chk=%b, expected done=0 chk=1",
               qed_done, qed_check);
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] alpha [4] = '{16'h00AA, 16'h0055, 16'h00AB, 16'h1234};
    for (int it = 0; it < 10; it++) begin
      do_reset();
      for (int c = 0; c < 80; c++) begin
        reset     = ($urandom_range(99) < 2);
        clk_en    = ($urandom_range(9) != 0);
        in_valid  = $urandom_range(1);
        in_data   = alpha[$urandom_range(1)];
        orig_mark = ($urandom_range(3) == 0);
        dup_mark  = $urandom_range(1);
        out_valid = $urandom_range(1);
        out_rdy   = ($urandom_range(3) != 0);
        out_data  = alpha[$urandom_range(3)];
        step();
        checks++;
        if (orig_captured !== (m_orig >= 0)) begin
          errors++;
          $display("FAIL rand_cap: it %0d cyc %0d got %b, expected %b",
                   it, c, orig_captured, (m_orig >= 0));
        end
        checks++;
        if (qed_done !== m_done) begin
          errors++;
          $display("FAIL rand_done: it %0d cyc %0d got %b, expected %b",
                   it, c, qed_done, m_done);
        end
        checks++;
        if (qed_check !== m_chk) begin
          errors++;
          $display("FAIL rand_check: it %0d cyc %0d got %b, expected %b",
                   it, c, qed_check, m_chk);
        end
      end
      idle_inputs();
    end
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    test_reset();
    test_basic("match", 16'h00AA, 1'b1, 1'b1);
    test_basic("mismatch", 16'h00AB, 1'b0, 1'b1);
    test_done_hold();
    test_dup_mismatch();
    test_backpressure();
    test_clk_en();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aqed_fc_tracker.md
Name: aqed_fc_tracker

Overview:
- Self-contained A-QED functional-consistency tracker that sits directly downstream of the memory core when the core runs in FIFO mode.
- Snoops the core's write side (accepted inputs) and read side (output handshakes).
- A free "original" input marks one accepted word; a later accepted word with identical data is marked "duplicate". The tracker captures the two core outputs with the same ordinal indices and compares them.
- Drives qed_done/qed_check for the formal top's qed_done |-> qed_check property.

Parameters:
DATA_WIDTH, 16, width of data words into and out of the core
CNT_WIDTH, 16, width of the input/output ordinal counters

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
clk_en  input  1  global enable; when 0 all state holds
in_data  input  DATA_WIDTH  word presented to the core's data_in
in_valid  input  1  core wen_in; word accepted when clk_en && in_valid
orig_mark  input  1  free (solver-driven) input; tags the current accepted word as original
dup_mark  input  1  free input; tags the current accepted word as duplicate
out_data  input  DATA_WIDTH  core data_out
out_valid  input  1  core valid_out
out_rdy  input  1  consumer ready (core ren_in); output consumed when clk_en && out_valid && out_rdy
orig_captured  output  1  original input has been recorded
qed_done  output  1  both outputs captured, comparison valid (sticky)
qed_check  output  1  comparison result; 1 whenever qed_done=0

Behaviour:
- Events: acc = clk_en && in_valid; cons = clk_en && out_valid && out_rdy.
- in_cnt increments on acc. out_cnt increments on cons. Both saturate at all-ones.
- An acc occurring while in_cnt is all-ones cannot be marked.
- FSM states: IDLE, ORIG_SET, DUP_SET, DONE. The state register is updated only when clk_en=1.
- IDLE:
  - acc && orig_mark (in_cnt not saturated): orig_data <= in_data, orig_idx <= in_cnt, go to ORIG_SET.
  - dup_mark is ignored in IDLE, including in the same cycle as orig_mark.
- ORIG_SET:
  - acc && dup_mark && in_data == orig_data && in_cnt not saturated: dup_idx <= in_cnt, go to DUP_SET.
  - dup_mark on mismatched data is ignored; the FSM stays in ORIG_SET.
  - orig_mark is ignored.
- Original-output capture:
  - Condition: state is ORIG_SET or DUP_SET, cons, out_cnt == orig_idx, orig_out_vld == 0.
  - Action: orig_out <= out_data, orig_out_vld <= 1.
  - Can occur before the duplicate is marked.
- Duplicate-output capture:
  - Condition: state is DUP_SET, cons, out_cnt == dup_idx.
  - Action: dup_out <= out_data, dup_out_vld <= 1.
- DUP_SET → DONE when orig_out_vld && dup_out_vld (registered values). The transition occurs on the cycle after the later capture.
- In DONE:
  - qed_done = 1, qed_check = (orig_out == dup_out).
  - Both are registered and held until reset; further traffic is ignored.
- Outputs are registered; qed_done rises one cycle after the second capture edge.
- Comparisons use exact DATA_WIDTH equality with no masking.
- The counters are free-running and independent of the FSM; out_cnt counts every consumption, including those before orig_mark.
- Reset values: state=IDLE, in_cnt=0, out_cnt=0, orig_out_vld=0, dup_out_vld=0, orig_captured=0, qed_done=0, qed_check=1. Data registers are don't-care.
- Reset mid-operation, in any state: next cycle all reset values; in-flight captures are discarded.
- clk_en=0: nothing updates, including counters and captures, regardless of in_valid/out_valid.
- Simultaneous acc and cons in one cycle: both counters update; marking and capture are evaluated independently against pre-update counter values.

Test Plan:
1. Reset, then accept 0x00AA (orig_mark), 0x0055, 0x00AA (dup_mark) at in_cnt 0,1,2; consume 0x00AA, 0x0055, 0x00AA with out_rdy=1 → qed_done=1 one cycle after the third consume, qed_check=1; orig_captured=1 from the cycle after the first accept.
2. As scenario 1, but the third consumed word is 0x00AB → qed_done=1, qed_check=0.
3. Orig 0x00AA, then dup_mark on 0x0055 → stays ORIG_SET; a later dup_mark on 0x00AA at in_cnt 3 with four consumes 0xAA,0x55,0x11,0xAA → qed_done=1, qed_check=1.
4. out_valid=1 with out_rdy=0 for 4 cycles → out_cnt unchanged, no capture; raising out_rdy captures the word with index 0.
5. clk_en=0 for 3 cycles with in_valid=1, out_valid=1, out_rdy=1, orig_mark=1 → in_cnt, out_cnt and state unchanged, orig_captured stays 0.
6. Reach DUP_SET with the original output captured, assert reset for 1 cycle → qed_done=0, qed_check=1, orig_captured=0, counters 0; repeating scenario 1 afterwards passes.
